// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that drives the select of a 4:1 data mux.
// It issues a registered one-hot grant and presents the granted requester's data
// on a valid/ready channel. While other requesters are waiting, each grant is
// limited to MAX_BURST transfers, so no requester can starve the others.
module mux_rr_arbiter #(
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] data_c,
  input  logic [DATA_W-1:0] data_d,
  input  logic              out_ready,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // Highest value of the transfer count; the count saturates here.
  localparam logic [3:0] CntMax = 4'(MAX_BURST - 1);

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        xfer;
  logic [3:0]  maskedReq;
  logic        relA;
  logic        relB;
  logic [2:0]  win;

  // Scans r starting one past l and wrapping back to l itself.
  // Returns {found, index}. The loop runs from the farthest candidate to the
  // nearest one, so the nearest asserted requester overwrites the others and wins.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] l);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = l + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign gnt = gnt_q;
  assign sel = sel_q;

  // Output channel: valid follows the granted request, and data follows sel even while idle.
  always_comb begin
    out_valid = |(gnt_q & req);
    unique case (sel_q)
      2'b00:   out_data = data_a;
      2'b01:   out_data = data_b;
      2'b10:   out_data = data_c;
      default: out_data = data_d;
    endcase
  end

  // Next state: grants on request, releases on a request drop or when the burst cap is reached.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    xfer      = out_valid && out_ready;
    maskedReq = req & ~gnt_q;
    relA      = 1'b0;
    relB      = 1'b0;
    win       = 3'b000;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win     = arbitrate(req, last_q);
          state_d = BUSY;
          gnt_d   = 4'b0001 << win[1:0];
          sel_d   = win[1:0];
          last_d  = win[1:0];
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        relA = !req[sel_q];
        relB = xfer && (cnt_q == CntMax) && (|maskedReq);
        if (relA || relB) begin
          win = arbitrate(maskedReq, last_q);
          if (win[2]) begin
            gnt_d  = 4'b0001 << win[1:0];
            sel_d  = win[1:0];
            last_d = win[1:0];
            cnt_d  = 4'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
          end
        end else if (xfer && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset sets last to 3 so that requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: a table of per-cycle vectors for the full round-robin
// rotation, followed by hand-written sequences for the multi-cycle corner cases.
module tb_mux_rr_arbiter;

  localparam int DATA_W = 4;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] data_a, data_b, data_c, data_d;
  logic              out_ready;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  int checkCount;
  int passCount;

  typedef struct {
    logic [3:0] vReq;
    logic       vReady;
    logic [3:0] expGnt;
    logic [1:0] expSel;
    logic       expValid;
  } vector_t;

  vector_t vecs[18];

  mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the request and ready inputs.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
  endtask

  // Compares the four outputs with expected values. The expected data is derived from the expected sel.
  task automatic checkOutput(input string name, input logic [3:0] eGnt,
                             input logic [1:0] eSel, input logic eValid);
    logic [DATA_W-1:0] eData;
    #1;
    case (eSel)
      2'b00:   eData = data_a;
      2'b01:   eData = data_b;
      2'b10:   eData = data_c;
      default: eData = data_d;
    endcase
    checkCount++;
    if (gnt === eGnt && sel === eSel && out_valid === eValid && out_data === eData) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got gnt=%b sel=%b valid=%b data=%h, expected gnt=%b sel=%b valid=%b data=%h",
               name, gnt, sel, out_valid, out_data, eGnt, eSel, eValid, eData);
    end
  endtask

  // Advances to 1 time unit past the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Applies reset for a cycle and then releases it away from the rising edge.
  task automatic doReset();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    checkOutput("reset_held", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    data_a = 4'hA;
    data_b = 4'hB;
    data_c = 4'hC;
    data_d = 4'hD;
    req       = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Full rotation with every request held and MAX_BURST = 4.
    vecs[0] = '{4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0};
    for (int i = 1; i <= 16; i++) begin
      vecs[i].vReq     = 4'b1111;
      vecs[i].vReady   = 1'b1;
      vecs[i].expGnt   = 4'b0001 << ((i - 1) / 4);
      vecs[i].expSel   = 2'((i - 1) / 4);
      vecs[i].expValid = 1'b1;
    end
    vecs[17] = '{4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1};

    #12;
    checkOutput("reset_initial", 4'b0000, 2'b00, 1'b0);
    doReset();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].vReq, vecs[i].vReady);
      checkOutput($sformatf("rotate_%0d", i), vecs[i].expGnt, vecs[i].expSel, vecs[i].expValid);
      stepCycle();
    end

    // Single request: one-cycle grant latency.
    doReset();
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_idle", 4'b0000, 2'b00, 1'b0);
    stepCycle();
    checkOutput("single_grant", 4'b0001, 2'b00, 1'b1);

    // Requester 2 alone keeps its grant past the burst cap, then yields once requester 0 arrives.
    doReset();
    applyStimulus(4'b0100, 1'b1);
    stepCycle();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("solo_c_%0d", i), 4'b0100, 2'b10, 1'b1);
      stepCycle();
    end
    applyStimulus(4'b0101, 1'b1);
    checkOutput("solo_c_compete", 4'b0100, 2'b10, 1'b1);
    stepCycle();
    checkOutput("solo_c_handover", 4'b0001, 2'b00, 1'b1);

    // With out_ready low the grant holds and no transfers are counted.
    doReset();
    applyStimulus(4'b0010, 1'b0);
    stepCycle();
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("stall_b_%0d", i), 4'b0010, 2'b01, 1'b1);
      stepCycle();
    end
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall_b_burst_%0d", i), 4'b0010, 2'b01, 1'b1);
      stepCycle();
    end
    checkOutput("stall_b_next", 4'b0100, 2'b10, 1'b1);

    // Request drop with no other requester: go idle and keep sel.
    doReset();
    applyStimulus(4'b1000, 1'b1);
    stepCycle();
    checkOutput("drop_d_grant", 4'b1000, 2'b11, 1'b1);
    stepCycle();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drop_d_dead", 4'b1000, 2'b11, 1'b0);
    stepCycle();
    checkOutput("drop_d_idle", 4'b0000, 2'b11, 1'b0);
    applyStimulus(4'b1001, 1'b1);
    stepCycle();
    checkOutput("drop_d_rotate", 4'b0001, 2'b00, 1'b1);

    // Request drop with a competitor: one dead cycle, then hand over.
    applyStimulus(4'b1000, 1'b1);
    checkOutput("drop_a_dead", 4'b0001, 2'b00, 1'b0);
    stepCycle();
    checkOutput("drop_a_handover", 4'b1000, 2'b11, 1'b1);

    // Reset asserted mid-burst clears the outputs immediately.
    doReset();
    applyStimulus(4'b0100, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("midrst_before", 4'b0100, 2'b10, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    rst_n = 1'b0;
    checkOutput("midrst_async", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("midrst_regrant", 4'b0001, 2'b00, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 data multiplexer among four requesters. It owns the 2-bit `sel` of the mux and issues a one-hot grant. It presents the selected requester's data on a valid/ready output channel. It caps each grant at a configurable burst length whenever other requesters are waiting, so no requester can starve the others.

## Interface
- `DATA_W`, 4, width of each data input and of `out_data`.
- `MAX_BURST`, 4, maximum transfers per grant while another requester is pending; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `req`  input  4  request per requester; bit i is requester i (0=a, 1=b, 2=c, 3=d).
- `data_a`, `data_b`, `data_c`, `data_d`  input  DATA_W each  requester data, routed by `sel` (00=a, 01=b, 10=c, 11=d).
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `gnt`  output  4  registered one-hot grant; all-zero when idle.
- `sel`  output  2  registered mux select; encodes the granted index.
- `out_valid`  output  1  combinational; equals `|(gnt & req)`.
- `out_data`  output  DATA_W  combinational mux output selected by `sel`.

## Operation
- State machine has two states: IDLE and BUSY.
- Registered state:
  - `state`.
  - `gnt`.
  - `sel`.
  - `last`, the 2-bit index of the most recent grant.
  - `cnt`, a 4-bit count of transfers in the current grant.
- Arbitration function: scan `req` in the order last+1, last+2, last+3, last (all mod 4). Pick the first requester that is asserted.
- IDLE:
  - `gnt` is 0 and `out_valid` is 0.
  - If `req` is nonzero, arbitrate. Load `gnt`/`sel`/`last` with the winner, clear `cnt`, and go to BUSY.
- BUSY:
  - A transfer occurs on a cycle with `out_valid` && `out_ready`. Each transfer increments `cnt`.
  - The grant releases at the clock edge of any cycle where either of the following holds:
    - (a) `req[sel]` is 0.
    - (b) a transfer occurs, `cnt` == MAX_BURST-1, and some other requester's `req` bit is 1.
  - On release, arbitrate over `req` with the current requester's bit masked off:
    - Winner found: load it, clear `cnt`, and stay in BUSY.
    - No winner under (a): go to IDLE, clear `gnt`, and leave `sel` unchanged.
  - Case (b) always has a winner, by definition.
  - Burst limit without competitors: if `cnt` reaches MAX_BURST-1 on a transfer and no other requester is pending, the grant is retained. `cnt` saturates at MAX_BURST-1 and does not wrap. The next transfer made while another requester is pending then triggers release (b).
- Requesters must keep `req` high until their data is consumed. Dropping `req` ends the grant regardless of pending data.
- `out_data` always equals the input selected by the current `sel`, including while idle.

## Timing
- Reset (asynchronous assert; release synchronous to `clk` externally):
  - `state` = IDLE.
  - `gnt` = 4'b0000.
  - `sel` = 2'b00.
  - `last` = 2'b11, so requester 0 has first priority.
  - `cnt` = 0.
  - `out_valid` = 0 and `out_data` = `data_a`.
- Request-to-grant latency: 1 cycle. A `req` sampled in IDLE at edge N produces `gnt`/`sel` after edge N. `out_valid` is high in cycle N+1.
- Back-to-back handover on a burst limit (b): the new grant is visible the cycle after the last transfer, with no bubble.
- Handover on a `req` drop (a): one dead cycle, the cycle in which `req[sel]` is low and `out_valid` is 0.
- If (a) and (b) occur in the same cycle, the behaviour is identical to (b).
- Reset mid-burst: all outputs return to reset values immediately. An in-flight transfer is not completed.
- `out_ready` held low: the grant stays put indefinitely while `req[sel]` stays high.

## Test plan
- Reset, then `req`=4'b0001 in IDLE -> next cycle `gnt`=0001, `sel`=00, `out_valid`=1, `out_data`=`data_a`.
- `req`=4'b1111 held, `out_ready`=1, MAX_BURST=4 -> 4 transfers each from requester 0, then 1, 2, 3, 0. `gnt` changes every 4th cycle with no bubble.
- Requester 2 alone, `out_ready`=1 for 10 cycles -> `gnt`=0100 throughout with no release. Then `req[0]` rises -> after the next transfer `gnt`=0001.
- Grant to requester 1, `out_ready`=0 for 6 cycles with `req`=1111 -> `gnt` stays 0010 and `cnt` stays 0.
- Grant to requester 3, `req[3]` drops, others idle -> the cycle after the drop `gnt`=0000 and `sel` stays 11. Then `req`=0001 -> `gnt`=0001 (rotation starts from last+1=0).
- Assert `rst_n`=0 mid-burst on requester 2 -> same cycle `gnt`=0000, `sel`=00, `out_valid`=0. After release, `req`=1111 -> requester 0 is granted first.
